// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode-side controls and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_instr;
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [31:0]           if_id_instr;
    logic [ADDR_WIDTH-1:0] if_id_pc;
    logic                  if_id_valid;
    logic                  halted;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, handles stall/redirect/halt.
// Optional macro FETCH_JUMP_PREDECODE_EN: J opcodes steer next_pc without a bubble.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [31:0]           HALT_WORD  = 32'hFC000000,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] ifPc_q, ifPc_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] nextPc;

    always_comb begin
`ifdef FETCH_JUMP_PREDECODE_EN
        if (bus.imem_instr[31:26] == 6'b000110) begin
            nextPc = bus.imem_instr[ADDR_WIDTH-1:0];
        end else begin
            nextPc = pc_q + PC_ONE;
        end
`else
        nextPc = pc_q + PC_ONE;
`endif
    end

    // Redirect outranks stall so a resolved branch is never lost behind a decode stall.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifPc_d   = ifPc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            S_BOOT: begin
                valid_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_target;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    valid_d = valid_q;
                end else if (bus.imem_instr == HALT_WORD) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    instr_d = bus.imem_instr;
                    ifPc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = nextPc;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            S_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ifPc_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifPc_q   <= ifPc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifPc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] mem [0:31];
    int nCompared = 0;
    int nMismatched = 0;

    // Reference model state
    int  mPc, mIfPc, mCount;
    logic [31:0] mInstr;
    bit  mValid, mHalted, mBoot;

    fetch_stage_if #(.ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    always #5 clk = ~clk;

    function automatic logic [31:0] benignWord();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b111111 || w[31:26] == 6'b000110) w[31:26] = 6'b000001;
        return w;
    endfunction

    task automatic fillMem();
        for (int i = 0; i < 32; i++) mem[i] = benignWord();
    endtask

    // One clock: drive inputs, advance the model from the pre-edge view, sample after the edge.
    task automatic step(input bit rst, input bit st, input bit rv, input int tgt);
        logic [31:0] w;
        reset = rst;
        bus.stall = st;
        bus.redirect_valid = rv;
        bus.redirect_target = 5'(tgt);
        w = mem[mPc];
        @(posedge clk);
        #1;
        if (rst) begin
            mBoot = 1; mPc = 0; mInstr = 0; mIfPc = 0; mValid = 0; mHalted = 0; mCount = 0;
        end else if (mHalted) begin
            mValid = 0;
        end else if (mBoot) begin
            mBoot = 0; mValid = 0;
        end else if (rv) begin
            mPc = tgt % 32; mValid = 0;
        end else if (st) begin
            mValid = mValid;
        end else if (w == HALT) begin
            mValid = 0; mHalted = 1;
        end else begin
            mInstr = w; mIfPc = mPc; mValid = 1;
            mCount = (mCount == 65535) ? 65535 : mCount + 1;
`ifdef FETCH_JUMP_PREDECODE_EN
            if (w[31:26] == 6'b000110) mPc = int'(w[4:0]);
            else mPc = (mPc + 1) % 32;
`else
            mPc = (mPc + 1) % 32;
`endif
        end
    endtask

    task automatic doReset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic runUntilIssued(input int a, input string tag);
        int n = 0;
        while (!(bus.if_id_valid === 1'b1 && int'(bus.if_id_pc) == a) && n < 80) begin
            step(0, 0, 0, 0);
            n++;
        end
        nCompared++;
        if (n >= 80) begin
            nMismatched++;
            $display("[TB] FAIL %s timeout: if_id_pc=%0d wanted %0d issued", tag, bus.if_id_pc, a);
        end
    endtask

    task automatic test_reset();
        fillMem();
        mem[0] = 32'h0C0A000A;
        mem[1] = 32'h0C0F000F;
        doReset();
        nCompared++;
        if ({bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.halted, bus.fetch_count} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: addr=%0d instr=%h pc=%0d v=%b h=%b cnt=%0d required all zero",
                     bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.halted, bus.fetch_count);
        end
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL boot_cycle: valid=%b addr=%0d required 0/0", bus.if_id_valid, bus.imem_addr);
        end
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 5'd0 || bus.if_id_instr !== 32'h0C0A000A) begin
            nMismatched++;
            $display("[TB] FAIL first_issue: v=%b pc=%0d instr=%h required 1/0/0c0a000a",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
        end
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_pc !== 5'd1 || bus.if_id_instr !== 32'h0C0F000F || bus.fetch_count !== 16'd2) begin
            nMismatched++;
            $display("[TB] FAIL second_issue: pc=%0d instr=%h cnt=%0d required 1/0c0f000f/2",
                     bus.if_id_pc, bus.if_id_instr, bus.fetch_count);
        end
    endtask

    task automatic test_jump();
        int seq[4];
        fillMem();
        mem[5] = {6'b000110, 26'd12};
        doReset();
        runUntilIssued(4, "jump_reach4");
        seq[0] = 4;
`ifdef FETCH_JUMP_PREDECODE_EN
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 0);
            seq[i] = bus.if_id_valid ? int'(bus.if_id_pc) : -1;
        end
        nCompared++;
        if (seq[1] != 5 || seq[2] != 12 || seq[3] != 13) begin
            nMismatched++;
            $display("[TB] FAIL jump_predecode: seq=%0d,%0d,%0d,%0d required 4,5,12,13", seq[0], seq[1], seq[2], seq[3]);
        end
`else
        step(0, 0, 0, 0);
        seq[1] = bus.if_id_valid ? int'(bus.if_id_pc) : -1;
        step(0, 0, 1, 12);
        seq[2] = bus.if_id_valid ? int'(bus.if_id_pc) : -1;
        step(0, 0, 0, 0);
        seq[3] = bus.if_id_valid ? int'(bus.if_id_pc) : -1;
        nCompared++;
        if (seq[1] != 5 || seq[2] != -1 || seq[3] != 12) begin
            nMismatched++;
            $display("[TB] FAIL jump_redirect: seq=%0d,%0d,%0d,%0d required 4,5,-1,12 (-1 = bubble)",
                     seq[0], seq[1], seq[2], seq[3]);
        end
`endif
    endtask

    task automatic test_stall();
        logic [15:0] cnt;
        fillMem();
        doReset();
        runUntilIssued(14, "stall_reach14");
        cnt = bus.fetch_count;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            nCompared++;
            if (bus.if_id_pc !== 5'd14 || bus.imem_addr !== 5'd15 || bus.fetch_count !== cnt || bus.if_id_valid !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold[%0d]: pc=%0d addr=%0d cnt=%0d v=%b required 14/15/%0d/1",
                         i, bus.if_id_pc, bus.imem_addr, bus.fetch_count, bus.if_id_valid, cnt);
            end
        end
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_pc !== 5'd15 || bus.if_id_instr !== mem[15] || bus.fetch_count !== cnt + 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL stall_resume: pc=%0d instr=%h cnt=%0d required 15/%h/%0d",
                     bus.if_id_pc, bus.if_id_instr, bus.fetch_count, mem[15], cnt + 16'd1);
        end
    endtask

    task automatic test_redirect_stall();
        runUntilIssued(17, "rs_reach17");
        step(0, 1, 1, 22);
        nCompared++;
        if (bus.imem_addr !== 5'd22 || bus.if_id_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL redirect_stall: addr=%0d v=%b required 22/0", bus.imem_addr, bus.if_id_valid);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 5'd22 || bus.if_id_instr !== mem[22]) begin
            nMismatched++;
            $display("[TB] FAIL redirect_issue: v=%b pc=%0d instr=%h required 1/22/%h",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, mem[22]);
        end
    endtask

    task automatic test_wrap();
        runUntilIssued(31, "wrap_reach31");
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL wrap: v=%b pc=%0d required 1/0", bus.if_id_valid, bus.if_id_pc);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        int lastPc = -1;
        fillMem();
        mem[7] = HALT;
        doReset();
        while (bus.halted !== 1'b1 && n < 40) begin
            step(0, 0, 0, 0);
            if (bus.if_id_valid === 1'b1) lastPc = int'(bus.if_id_pc);
            n++;
        end
        nCompared++;
        if (bus.halted !== 1'b1 || lastPc != 6 || bus.imem_addr !== 5'd7 || bus.if_id_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL halt_entry: h=%b lastPc=%0d addr=%0d v=%b required 1/6/7/0",
                     bus.halted, lastPc, bus.imem_addr, bus.if_id_valid);
        end
        step(0, 0, 1, 3);
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.halted !== 1'b1 || bus.imem_addr !== 5'd7 || bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 5'd6) begin
            nMismatched++;
            $display("[TB] FAIL halt_ignores_redirect: h=%b addr=%0d v=%b pc=%0d required 1/7/0/6",
                     bus.halted, bus.imem_addr, bus.if_id_valid, bus.if_id_pc);
        end
    endtask

    task automatic test_reset_midrun();
        step(1, 0, 0, 0);
        nCompared++;
        if (bus.imem_addr !== 5'd0 || bus.if_id_valid !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_count !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_in_halt: addr=%0d v=%b h=%b cnt=%0d required 0/0/0/0",
                     bus.imem_addr, bus.if_id_valid, bus.halted, bus.fetch_count);
        end
        mem[7] = benignWord();
        runUntilIssued(8, "midstall_reach8");
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        nCompared++;
        if (bus.imem_addr !== 5'd0 || bus.if_id_valid !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_count !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_stall: addr=%0d v=%b h=%b cnt=%0d required 0/0/0/0",
                     bus.imem_addr, bus.if_id_valid, bus.halted, bus.fetch_count);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        nCompared++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 5'd0 || bus.fetch_count !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL reset_reboot: v=%b pc=%0d cnt=%0d required 1/0/1",
                     bus.if_id_valid, bus.if_id_pc, bus.fetch_count);
        end
    endtask

    task automatic test_random();
        fillMem();
        for (int i = 0; i < 3; i++) mem[$urandom_range(31)] = {6'b000110, 21'd0, 5'($urandom_range(31))};
        mem[$urandom_range(31)] = HALT;
        doReset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 10, $urandom_range(31));
            nCompared++;
            if (bus.imem_addr !== 5'(mPc) || bus.if_id_valid !== mValid || bus.halted !== mHalted ||
                bus.fetch_count !== 16'(mCount) || bus.if_id_pc !== 5'(mIfPc) || bus.if_id_instr !== mInstr) begin
                nMismatched++;
                $display("[TB] FAIL random[%0d]: addr=%0d v=%b h=%b cnt=%0d pc=%0d instr=%h required %0d/%b/%b/%0d/%0d/%h",
                         c, bus.imem_addr, bus.if_id_valid, bus.halted, bus.fetch_count, bus.if_id_pc, bus.if_id_instr,
                         mPc, mValid, mHalted, mCount, mIfPc, mInstr);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        mPc = 0; mIfPc = 0; mCount = 0; mInstr = 0; mValid = 0; mHalted = 0; mBoot = 1;
        test_reset();
        test_jump();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_halt();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory's 5-bit word address.
- Captures the returned 32-bit instruction into an IF/ID register for decode.
- Handles stall, redirect/flush from branch resolution, an optional early jump redirect, and a halt state.

Parameters:
ADDR_WIDTH, 5, PC / instruction-memory word-address width (PC counts words)
HALT_WORD, 32'hFC000000, fetched encoding (opcode 6'b111111) that stops fetch
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 16, width of fetch counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_WIDTH  word address to instruction_memory (= pc, combinational from register)
imem_instr  in  32  instruction returned combinationally by instruction_memory for imem_addr
stall  in  1  decode cannot accept; hold PC and IF/ID register
redirect_valid  in  1  taken BEQ (or jump, see feature) resolved downstream; flush and redirect
redirect_target  in  ADDR_WIDTH  new PC on redirect
if_id_instr  out  32  registered instruction for decode
if_id_pc  out  ADDR_WIDTH  address of if_id_instr
if_id_valid  out  1  if_id_instr is a live instruction
halted  out  1  fetch has stopped on HALT_WORD
fetch_count  out  CNT_WIDTH  number of instructions issued with if_id_valid=1, saturating

Behaviour:
- States: BOOT, RUN, HALT. Reset forces BOOT, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0. Reset wins over all other inputs, in any state and mid-stall.
- BOOT: one cycle with if_id_valid=0 and pc unchanged, then RUN. This lets memory output settle.
- RUN, per edge, in priority order:
  1. redirect_valid=1: pc<=redirect_target, if_id_valid<=0 (the word fetched this cycle is squashed). Applies even when stall=1.
  2. stall=1: pc, if_id_instr, if_id_pc, if_id_valid and fetch_count all hold.
  3. imem_instr==HALT_WORD: if_id_valid<=0, halted<=1, go to HALT. The halt word is never issued.
  4. Otherwise: if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1, fetch_count increments (saturating at all-ones), and pc<=next_pc.
- next_pc = pc+1 modulo 2^ADDR_WIDTH (31 wraps to 0), except as modified by the optional feature.
- Latency: the instruction at address A appears on if_id_instr one edge after pc==A with no stall or redirect.
- HALT: pc and if_id_* frozen, if_id_valid=0, halted=1. stall and redirect_valid are ignored. Only reset exits.
- imem_addr is always pc. It is never gated and is valid in every state.
- No X on outputs after reset, regardless of imem_instr content.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- Defined:
  - In RUN case 4, if imem_instr[31:26]==6'b000110 (J), next_pc=imem_instr[ADDR_WIDTH-1:0] instead of pc+1.
  - The J is still issued to decode with if_id_valid=1.
  - Decode must not also raise redirect_valid for J. If it does, redirect priority still holds.
- Undefined:
  - No opcode inspection in fetch; J gets next_pc=pc+1.
  - The jump is resolved only through redirect_valid.

Test Plan:
- Reset released at cycle 0, with ADDI r10 (32'h0C0A000A) at address 0 and ADDI r15 (32'h0C0F000F) at address 1 -> cycle 1 if_id_valid=0 (BOOT); cycle 2 if_id_pc=0, if_id_instr=32'h0C0A000A; cycle 3 if_id_pc=1, if_id_instr=32'h0C0F000F; fetch_count=2.
- FETCH_JUMP_PREDECODE_EN defined, J 12 at address 5 -> if_id_pc sequence 4,5,12,13 with no bubble. Undefined, with redirect_valid=1 and target 12 pulsed the cycle after address 5 issues -> sequence 4,5,(valid=0),12.
- stall held 3 cycles while if_id_pc=14 -> if_id_pc stays 14, imem_addr stays 15, fetch_count unchanged; then resumes with 15.
- redirect_valid=1, redirect_target=22 and stall=1 in the same cycle -> next edge pc=22, if_id_valid=0; next unstalled edge issues if_id_pc=22.
- Memory holding no halt word, run to pc=31 -> following issued if_id_pc=0 (wrap). HALT_WORD at address 7 -> halted=1, last issued if_id_pc=6, imem_addr frozen at 7, a later redirect is ignored.
- reset asserted in HALT, and again mid-stall at pc=9 -> next edge pc=0, if_id_valid=0, halted=0, fetch_count=0, state BOOT.
